sdram_traffic_gen: RTL and testbench

Parametrised, self-checking SDRAM traffic generator. It replaces the button-pulse stimulus in front of the SDRAM controller inside top. On a start pulse it writes a programmable data pattern over an address window, reads the window back with several reads in flight, compares every word and reports pass/fail, error count and first failing address. It sits between the start/button logic and the controller request/response port, in the CLOCK_100 domain.

---
 rtl/sdram_tg_pkg.sv | 27 ++
 rtl/sdram_pattern_gen.sv | 41 ++++
 rtl/sdram_traffic_gen.sv | 212 +++++++++++++++++++++
 tb/tb_sdram_traffic_gen.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_tg_pkg.sv
// Shared types and helpers for the SDRAM traffic generator.
//   state_e : pass sequencer states
//   mode_e  : data pattern selection
//   chk_bit : bit value of the even-index checkerboard word at a bit position
package sdram_tg_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MODE_INC  = 2'd0,
        MODE_WALK = 2'd1,
        MODE_INV  = 2'd2,
        MODE_CHK  = 2'd3
    } mode_e;

    // Even-index checkerboard word is {N{2'b10}}: odd bit positions are 1.
    function automatic logic chk_bit(input int pos);
        return pos[0];
    endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Combinational data pattern for one word of the test window.
// Ports:
//   mode    : pattern select (mode_e encoding)
//   idx     : word index within the window
//   addr_lo : low DATA_W bits of the word address (zero-extended if narrower)
//   pattern : expected / write data for that word
module sdram_pattern_gen
    import sdram_tg_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 24
) (
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] addr_lo,
    output logic [DATA_W-1:0] pattern
);

    logic [DATA_W-1:0] chk_even;
    logic [31:0]       walk_pos;

    always_comb begin
        chk_even = '0;
        for (int b = 0; b < DATA_W; b++) begin
            chk_even[b] = chk_bit(b);
        end
    end

    assign walk_pos = 32'(idx) % 32'(DATA_W);

    always_comb begin
        pattern = '0;
        case (mode_e'(mode))
            MODE_INC:  pattern = DATA_W'(idx);
            MODE_WALK: pattern = DATA_W'(1) << walk_pos;
            MODE_INV:  pattern = ~addr_lo;
            default:   pattern = idx[0] ? ~chk_even : chk_even;
        endcase
    end

endmodule

// File: rtl/sdram_traffic_gen.sv
// Self-checking SDRAM traffic generator. Writes a pattern over a word window,
// reads it back with up to MAX_OUTSTANDING reads in flight, compares each
// returned word and reports pass/fail, error count and first failing address.
// Ports:
//   CLOCK_100, rst          : clock, synchronous active-high reset
//   start, mode, loop_en    : pass control
//   req_*                   : controller request port (valid/ready)
//   rsp_valid, rsp_data     : in-order read responses
//   busy, done, pass        : pass status
//   err_count, first_err_addr, spurious, led : results
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for start
// WRITE | issuing pattern writes over the window
// READ  | issuing reads, throttled by outstanding count
// DRAIN | all reads issued, waiting for the last responses
// DONE  | one-cycle end of pass, result valid
module sdram_traffic_gen
    import sdram_tg_pkg::*;
#(
    parameter int          ADDR_W          = 24,
    parameter int          DATA_W          = 16,
    parameter int          NUM_WORDS       = 256,
    parameter int unsigned BASE_ADDR       = 0,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          ERR_W           = 16
) (
    input  logic              CLOCK_100,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              loop_en,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              spurious,
    output logic [7:0]        led
);

    localparam int               IDX_W    = $clog2(NUM_WORDS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(NUM_WORDS);
    localparam logic [3:0]       MAX_OS   = 4'(MAX_OUTSTANDING);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

    state_e            state;
    logic [1:0]        mode_q;
    logic [IDX_W-1:0]  wr_idx, rd_idx, rsp_idx;
    logic [3:0]        outstanding;

    logic              wr_hs, rd_hs, rsp_ok, rsp_spur, mismatch, restart;
    logic [3:0]        outstanding_nxt;
    logic [IDX_W-1:0]  rd_idx_nxt, rsp_idx_nxt, wr_sel_idx;
    logic [ERR_W-1:0]  err_nxt;
    logic              spurious_nxt;
    logic [1:0]        wr_mode_sel;
    logic [ADDR_W-1:0] wr_addr_nxt, rd_addr_nxt, exp_addr;
    logic [DATA_W-1:0] wr_data, exp_data;

    assign wr_hs    = req_valid && req_ready && req_we;
    assign rd_hs    = req_valid && req_ready && !req_we;
    assign rsp_ok   = rsp_valid && (outstanding != '0);
    assign rsp_spur = rsp_valid && (outstanding == '0);

    always_comb begin
        outstanding_nxt = outstanding;
        if (rd_hs && !rsp_ok) begin
            outstanding_nxt = outstanding + 4'd1;
        end else if (!rd_hs && rsp_ok) begin
            outstanding_nxt = outstanding - 4'd1;
        end
    end

    assign rd_idx_nxt   = rd_idx + IDX_W'(rd_hs);
    assign rsp_idx_nxt  = rsp_idx + IDX_W'(rsp_ok);
    assign rd_addr_nxt  = BASE + ADDR_W'(rd_idx_nxt);
    assign exp_addr     = BASE + ADDR_W'(rsp_idx);
    assign mismatch     = rsp_ok && (rsp_data != exp_data);
    assign err_nxt      = (mismatch && (err_count != '1)) ? err_count + 1'b1 : err_count;
    assign spurious_nxt = spurious | rsp_spur;

    // A new pass starts either from IDLE on start or from DONE when looping.
    assign restart     = ((state == IDLE) && start) || ((state == DONE) && loop_en);
    assign wr_mode_sel = (state == IDLE) ? mode : mode_q;
    assign wr_sel_idx  = restart ? '0 : wr_idx + 1'b1;
    assign wr_addr_nxt = BASE + ADDR_W'(wr_sel_idx);

    sdram_pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wr_pat (
        .mode    (wr_mode_sel),
        .idx     (ADDR_W'(wr_sel_idx)),
        .addr_lo (DATA_W'(wr_addr_nxt)),
        .pattern (wr_data)
    );

    sdram_pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_exp_pat (
        .mode    (mode_q),
        .idx     (ADDR_W'(rsp_idx)),
        .addr_lo (DATA_W'(exp_addr)),
        .pattern (exp_data)
    );

    always_ff @(posedge CLOCK_100) begin
        if (rst) begin
            state          <= IDLE;
            mode_q         <= '0;
            wr_idx         <= '0;
            rd_idx         <= '0;
            rsp_idx        <= '0;
            outstanding    <= '0;
            req_valid      <= 1'b0;
            req_we         <= 1'b0;
            req_addr       <= '0;
            req_wdata      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            spurious       <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt;
            rsp_idx     <= rsp_idx_nxt;
            err_count   <= err_nxt;
            spurious    <= spurious_nxt;
            done        <= 1'b0;
            if (mismatch && (err_count == '0)) begin
                first_err_addr <= exp_addr;
            end

            if (restart) begin
                if (state == IDLE) begin
                    mode_q <= mode;
                end
                state          <= WRITE;
                busy           <= 1'b1;
                pass           <= 1'b0;
                err_count      <= '0;
                first_err_addr <= '0;
                wr_idx         <= '0;
                rd_idx         <= '0;
                rsp_idx        <= '0;
                outstanding    <= '0;
                req_valid      <= 1'b1;
                req_we         <= 1'b1;
                req_addr       <= wr_addr_nxt;
                req_wdata      <= wr_data;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    WRITE: begin
                        if (wr_hs) begin
                            wr_idx <= wr_idx + 1'b1;
                            if (wr_idx == LAST_IDX) begin
                                // First read goes out right away; nothing is outstanding yet.
                                state     <= READ;
                                req_we    <= 1'b0;
                                req_addr  <= rd_addr_nxt;
                                req_wdata <= '0;
                            end else begin
                                req_addr  <= wr_addr_nxt;
                                req_wdata <= wr_data;
                            end
                        end
                    end
                    READ: begin
                        rd_idx   <= rd_idx_nxt;
                        req_addr <= rd_addr_nxt;
                        if (rd_hs && (rd_idx == LAST_IDX)) begin
                            state     <= DRAIN;
                            req_valid <= 1'b0;
                        end else begin
                            // Without a handshake outstanding cannot grow, so an
                            // asserted req_valid is never withdrawn here.
                            req_valid <= (outstanding_nxt < MAX_OS);
                        end
                    end
                    DRAIN: begin
                        // Look ahead at the response being accepted this cycle so
                        // done follows the final response by one cycle.
                        if (rsp_idx_nxt == N_IDX) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= (err_nxt == '0) && !spurious_nxt;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign led = {busy, pass, spurious, mode_q, (err_count != '0), 2'b00};

endmodule

// File: tb/tb_sdram_traffic_gen.sv
module tb_sdram_traffic_gen;

    localparam int N    = 16;
    localparam int AW   = 24;
    localparam int DW   = 16;
    localparam int MAXO = 4;
    localparam int EW   = 16;

    logic          CLOCK_100, rst, start, loop_en;
    logic [1:0]    mode;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          busy, done, pass, spurious;
    logic [EW-1:0] err_count;
    logic [AW-1:0] first_err_addr;
    logic [7:0]    led;

    sdram_traffic_gen #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(N), .BASE_ADDR(0),
        .MAX_OUTSTANDING(MAXO), .ERR_W(EW)
    ) dut (
        .CLOCK_100(CLOCK_100), .rst(rst), .start(start), .mode(mode), .loop_en(loop_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .spurious(spurious), .led(led)
    );

    initial begin
        CLOCK_100 = 1'b0;
        forever #5 CLOCK_100 = ~CLOCK_100;
    end

    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct packed { logic p; logic [EW-1:0] err; logic [AW-1:0] first; logic spur; logic [1:0] mode; } res_t;
    typedef struct packed { int due; logic [DW-1:0] data; } pend_t;

    wr_t           wq[$];
    logic [AW-1:0] rq[$];
    res_t          resq[$];
    pend_t         pend[$];

    int n_cmp = 0;
    int n_bad = 0;

    // memory model controls
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] stuck_mask [0:255];
    int  lat = 1;
    bit  rand_ready = 0;
    bit  inject_spur = 0;
    int  cyc = 0;

    // monitor state
    int  mcyc = 0, os_m = 0, os_max = 0, wr_cnt = 0, rd_cnt = 0, rsp_cnt = 0;
    int  last_rsp_cyc = 0, done_cnt = 0;
    bit  p_stall = 0;
    logic [AW+DW+1:0] p_req;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int m, input int i);
        logic [DW-1:0] one;
        one = 1;
        case (m)
            0:       return DW'(i);
            1:       return one << (i % DW);
            2:       return ~DW'(i);
            default: return ((i % 2) == 0) ? 16'hAAAA : 16'h5555;
        endcase
    endfunction

    task automatic push_pass(input int m, input bit p, input int err, input int first, input bit spur);
        wr_t  w;
        res_t r;
        for (int i = 0; i < N; i++) begin
            w.addr = AW'(i);
            w.data = pat(m, i);
            wq.push_back(w);
            rq.push_back(AW'(i));
        end
        r.p = p; r.err = EW'(err); r.first = AW'(first); r.spur = spur; r.mode = 2'(m);
        resq.push_back(r);
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 4000 && done_cnt < target; k++) @(negedge CLOCK_100);
        n_cmp++;
        if (done_cnt < target) begin
            n_bad++;
            $display("FAIL done_timeout: got %0d passes expected %0d", done_cnt, target);
        end
        repeat (3) @(negedge CLOCK_100);
    endtask

    task automatic pulse_start(input int m);
        start = 1'b1;
        mode  = 2'(m);
        @(negedge CLOCK_100);
        start = 1'b0;
    endtask

    // Memory / controller model: drives ready and responses just after negedge.
    initial begin
        pend_t         pe;
        logic [DW-1:0] d;
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        for (int a = 0; a < 256; a++) stuck_mask[a] = '0;
        forever begin
            @(negedge CLOCK_100);
            #1;
            cyc++;
            rsp_valid = 1'b0;
            if (rst) begin
                pend.delete();
                req_ready = 1'b1;
                continue;
            end
            if (inject_spur) begin
                rsp_valid   = 1'b1;
                rsp_data    = 16'h1234;
                inject_spur = 0;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                pe        = pend.pop_front();
                rsp_valid = 1'b1;
                rsp_data  = pe.data;
            end
            req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (req_valid && req_ready) begin
                if (req_we) begin
                    d = req_wdata & ~stuck_mask[req_addr[7:0]];
                    mem[req_addr[7:0]] = d;
                end else begin
                    pe.due  = cyc + lat;
                    pe.data = mem[req_addr[7:0]];
                    pend.push_back(pe);
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        wr_t  e;
        res_t r;
        logic [AW-1:0] ea;
        forever begin
            @(negedge CLOCK_100);
            #2;
            mcyc++;
            if (rst) begin
                os_m = 0; wr_cnt = 0; rd_cnt = 0; rsp_cnt = 0; p_stall = 0;
                continue;
            end
            if (p_stall) check("stall_hold", {req_valid, req_we, req_addr, req_wdata}, p_req);
            if (wr_cnt == N && rd_cnt < N) begin
                check("rd_valid_gate", req_valid, (os_m < MAXO));
                check("os_bound", (os_m <= MAXO), 1);
            end
            if (req_valid && req_ready) begin
                if (req_we) begin
                    if (wq.size() == 0) check("unexpected_write", req_addr, '1);
                    else begin
                        e = wq.pop_front();
                        check("write_req", {req_addr, req_wdata}, {e.addr, e.data});
                    end
                    wr_cnt++;
                end else begin
                    if (rq.size() == 0) check("unexpected_read", req_addr, '1);
                    else begin
                        ea = rq.pop_front();
                        check("read_addr", req_addr, ea);
                    end
                    rd_cnt++;
                end
            end
            if (done) begin
                done_cnt++;
                if (resq.size() == 0) check("unexpected_done", done, 0);
                else begin
                    r = resq.pop_front();
                    check("pass", pass, r.p);
                    check("err_count", err_count, r.err);
                    check("first_err_addr", first_err_addr, r.first);
                    check("led", led, {1'b1, r.p, r.spur, r.mode, (r.err != 0), 2'b00});
                    check("done_latency", mcyc, last_rsp_cyc + 1);
                    check("words_per_pass", {wr_cnt, rd_cnt}, {N, N});
                end
                wr_cnt = 0; rd_cnt = 0; rsp_cnt = 0;
            end
            if (req_valid && req_ready && !req_we) os_m++;
            if (rsp_valid && os_m > 0) begin
                os_m--;
                rsp_cnt++;
                if (rsp_cnt == N) last_rsp_cyc = mcyc;
            end
            if (os_m > os_max) os_max = os_m;
            p_stall = req_valid && !req_ready;
            p_req   = {req_valid, req_we, req_addr, req_wdata};
        end
    end

    // Stimulus
    initial begin
        int k;
        rst = 1'b1; start = 1'b0; mode = 2'd0; loop_en = 1'b0;
        repeat (3) @(negedge CLOCK_100);
        check("reset_outputs", {req_valid, req_we, req_addr, req_wdata, busy, done, pass,
                                err_count, first_err_addr, spurious, led}, '0);
        rst = 1'b0;
        @(negedge CLOCK_100);

        // clean pass, mode 0, 1-cycle latency
        push_pass(0, 1, 0, 0, 0);
        pulse_start(0);
        check("first_req", {req_valid, req_we, req_addr, req_wdata}, {1'b1, 1'b1, 24'd0, 16'd0});
        wait_done(1);

        // stuck bits: addr 5 loses bit 5, addr 9 loses bit 9 (walking one hits both)
        stuck_mask[5] = 16'h0020;
        stuck_mask[9] = 16'h0200;
        push_pass(1, 0, 2, 5, 0);
        pulse_start(1);
        wait_done(2);
        stuck_mask[5] = '0;
        stuck_mask[9] = '0;

        // 10-cycle latency, checkerboard, start while busy is ignored
        lat = 10;
        os_max = 0;
        push_pass(3, 1, 0, 0, 0);
        pulse_start(3);
        repeat (30) @(negedge CLOCK_100);
        pulse_start(0);
        wait_done(3);
        check("os_peak", os_max, MAXO);

        // random ready, inverted address pattern
        lat = 3;
        rand_ready = 1;
        push_pass(2, 1, 0, 0, 0);
        pulse_start(2);
        wait_done(4);
        rand_ready = 0;
        lat = 1;

        // spurious response while idle taints the next clean pass
        inject_spur = 1;
        repeat (3) @(negedge CLOCK_100);
        check("spurious_set", spurious, 1);
        push_pass(0, 0, 0, 0, 1);
        pulse_start(0);
        wait_done(5);

        // reset during READ with 3 reads outstanding
        lat = 10;
        push_pass(1, 1, 0, 0, 0);
        pulse_start(1);
        for (k = 0; k < 500; k++) begin
            if (wr_cnt == N && os_m == 3) break;
            @(negedge CLOCK_100);
        end
        check("reached_3_outstanding", os_m, 3);
        rst = 1'b1;
        wq.delete(); rq.delete(); resq.delete();
        @(negedge CLOCK_100);
        check("rst_outputs", {req_valid, req_we, req_addr, req_wdata, busy, done, pass,
                              err_count, first_err_addr, spurious, led}, '0);
        rst = 1'b0;
        lat = 1;
        @(negedge CLOCK_100);
        push_pass(2, 1, 0, 0, 0);
        pulse_start(2);
        wait_done(6);

        // loop mode: two back-to-back passes, then stop
        lat = 2;
        push_pass(3, 1, 0, 0, 0);
        push_pass(3, 1, 0, 0, 0);
        loop_en = 1'b1;
        pulse_start(3);
        for (k = 0; k < 4000 && done_cnt < 7; k++) @(negedge CLOCK_100);
        loop_en = 1'b0;
        check("loop_restart_busy", busy, 1);
        wait_done(8);
        repeat (30) @(negedge CLOCK_100);
        check("done_per_pass", done_cnt, 8);
        check("idle_after_loop", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
